// File: rtl/addr_bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester address bus arbiter.
// Imported by the interface, the round-robin picker and the arbiter top.
package addr_bus_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;
    localparam int HOLD_W     = 4;

    localparam logic [2:0] EN0_ADDR_DEF = 3'b001;
    localparam logic [2:0] EN1_ADDR_DEF = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } owner_t;

    // The hold counter counts down to zero, so it is loaded with one less than the window.
    function automatic logic [HOLD_W-1:0] hold_load(input int hold);
        return HOLD_W'(hold - 1);
    endfunction

endpackage

// File: rtl/addr_bus_arbiter_if.sv
// Requester-side and shared-bus signals of the address bus arbiter.
// master: arbiter side; slave: requesters plus the enable demux consumer.
interface addr_bus_arbiter_if
    import addr_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              we0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              we1;

    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA;
    logic              WE;
    logic              enable0;
    logic              enable1;

    modport master (
        input  req0, addr0, wdata0, we0,
        input  req1, addr1, wdata1, we1,
        output gnt0, gnt1, ack0, ack1,
        output ADDR, WDATA, WE, enable0, enable1
    );

    modport slave (
        output req0, addr0, wdata0, we0,
        output req1, addr1, wdata1, we1,
        input  gnt0, gnt1, ack0, ack1,
        input  ADDR, WDATA, WE, enable0, enable1
    );

endinterface

// File: rtl/addr_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// A lone requester always wins; under contention the one that did not go last wins.
module rr_arb2
    import addr_bus_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t owner
);

    always_comb begin
        valid = req0 | req1;
        owner = OWN0;
        if (req0 && req1) begin
            owner = (last_owner == OWN0) ? OWN1 : OWN0;
        end else if (req1) begin
            owner = OWN1;
        end
    end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared address bus feeding the enable demux.
// state | meaning
// IDLE  | bus cleared, pick an owner from pending requests
// BUSY  | owner's access latched and held for HOLD_CYCLES cycles
// DONE  | bus cleared, one-cycle ack to the owner, round-robin pointer updated
module addr_bus_arbiter
    import addr_bus_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                HOLD_CYCLES = 2,
    parameter logic [ADDR_W-1:0] EN0_ADDR    = ADDR_W'(EN0_ADDR_DEF),
    parameter logic [ADDR_W-1:0] EN1_ADDR    = ADDR_W'(EN1_ADDR_DEF)
) (
    input  logic                CLK,
    input  logic                RESET,
    addr_bus_arbiter_if.master  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = hold_load(HOLD_CYCLES);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    owner_t            last_q, last_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              en0_q, en0_d;
    logic              en1_q, en1_d;

    logic              pick_valid;
    owner_t            pick_owner;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    rr_arb2 u_rr_arb2 (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_owner (last_q),
        .valid      (pick_valid),
        .owner      (pick_owner)
    );

    always_comb begin
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        sel_we    = bus.we0;
        if (pick_owner == OWN1) begin
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
            sel_we    = bus.we1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= OWN1;
            owner_q <= OWN0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            en0_q   <= 1'b0;
            en1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            en0_q   <= en0_d;
            en1_q   <= en1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        en0_d   = en0_q;
        en1_d   = en1_q;

        case (state_q)
            IDLE: begin
                addr_d  = '0;
                wdata_d = '0;
                we_d    = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                en0_d   = 1'b0;
                en1_d   = 1'b0;
                if (pick_valid) begin
                    owner_d = pick_owner;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    gnt0_d  = (pick_owner == OWN0);
                    gnt1_d  = (pick_owner == OWN1);
                    // Enables are registered alongside ADDR so the demux never sees a decode glitch.
                    en0_d   = (sel_addr == EN0_ADDR);
                    en1_d   = (sel_addr == EN1_ADDR);
                    cnt_d   = HOLD_LOAD;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (cnt_q == '0) begin
                    addr_d  = '0;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    en0_d   = 1'b0;
                    en1_d   = 1'b0;
                    ack0_d  = (owner_q == OWN0);
                    ack1_d  = (owner_q == OWN1);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end

            default: begin
                addr_d  = '0;
                wdata_d = '0;
                we_d    = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                en0_d   = 1'b0;
                en1_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.ADDR    = addr_q;
    assign bus.WDATA   = wdata_q;
    assign bus.WE      = we_q;
    assign bus.enable0 = en0_q;
    assign bus.enable1 = en1_q;

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (RESET) !(gnt0_q && gnt1_q));
    a_ack_onehot: assert property (@(posedge CLK) disable iff (RESET) !(ack0_q && ack1_q));
    a_en_onehot:  assert property (@(posedge CLK) disable iff (RESET) !(en0_q && en1_q));

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Directed bench for addr_bus_arbiter: a cycle-by-cycle vector table followed by
// a continuous-contention sequence checking round-robin order and exclusivity.
module tb_addr_bus_arbiter;
    import addr_bus_pkg::*;

    localparam int AW   = 3;
    localparam int DW   = 4;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    addr_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    addr_bus_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .HOLD_CYCLES (HOLD),
        .EN0_ADDR    (3'b001),
        .EN1_ADDR    (3'b010)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // Output word: {gnt0, gnt1, ack0, ack1, ADDR[2:0], WDATA[3:0], WE, enable0, enable1}
    typedef struct {
        logic        rst;
        logic        r0;
        logic [2:0]  a0;
        logic [3:0]  d0;
        logic        w0;
        logic        r1;
        logic [2:0]  a1;
        logic [3:0]  d1;
        logic        w1;
        logic [13:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [13:0] ob(input logic g0, input logic g1, input logic k0,
                                       input logic k1, input logic [2:0] a, input logic [3:0] d,
                                       input logic w, input logic e0, input logic e1);
        return {g0, g1, k0, k1, a, d, w, e0, e1};
    endfunction

    function automatic vec_t mk(input logic rs, input logic r0, input logic [2:0] a0,
                                input logic [3:0] d0, input logic w0, input logic r1,
                                input logic [2:0] a1, input logic [3:0] d1, input logic w1,
                                input logic [13:0] e);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.a0 = a0; v.d0 = d0; v.w0 = w0;
        v.r1 = r1;  v.a1 = a1; v.d1 = d1; v.w1 = w1; v.exp = e;
        return v;
    endfunction

    function automatic logic [13:0] obs();
        return {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.ADDR, bus.WDATA,
                bus.WE, bus.enable0, bus.enable1};
    endfunction

    task automatic drive(input vec_t v);
        rst        = v.rst;
        bus.req0   = v.r0;
        bus.addr0  = v.a0;
        bus.wdata0 = v.d0;
        bus.we0    = v.w0;
        bus.req1   = v.r1;
        bus.addr1  = v.a1;
        bus.wdata1 = v.d1;
        bus.we1    = v.w1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vq[$];
        logic [13:0] got;
        logic [13:0] z;
        logic [13:0] g0w, g1c, g0r, g1u, g1w, k0, k1;
        logic        prev_any;
        logic        cur_any;
        logic        exp_owner;
        int          grants;
        int          acks;

        z   = 14'h0;
        k0  = ob(0, 0, 1, 0, 3'b000, 4'h0, 0, 0, 0);
        k1  = ob(0, 0, 0, 1, 3'b000, 4'h0, 0, 0, 0);
        g0w = ob(1, 0, 0, 0, 3'b001, 4'hA, 1, 1, 0);
        g1c = ob(0, 1, 0, 0, 3'b010, 4'h5, 0, 0, 1);
        g0r = ob(1, 0, 0, 0, 3'b001, 4'h3, 1, 1, 0);
        g1u = ob(0, 1, 0, 0, 3'b111, 4'hC, 1, 0, 0);
        g1w = ob(0, 1, 0, 0, 3'b010, 4'h7, 1, 0, 1);

        // reset held with req0 pending, then single write from requester 0
        vq.push_back(mk(1, 1, 3'b001, 4'hA, 1, 0, 3'b000, 4'h0, 0, z));
        vq.push_back(mk(1, 1, 3'b001, 4'hA, 1, 0, 3'b000, 4'h0, 0, z));
        vq.push_back(mk(0, 1, 3'b001, 4'hA, 1, 0, 3'b000, 4'h0, 0, g0w));
        vq.push_back(mk(0, 1, 3'b001, 4'hA, 1, 0, 3'b000, 4'h0, 0, g0w));
        vq.push_back(mk(0, 1, 3'b001, 4'hA, 1, 0, 3'b000, 4'h0, 0, k0));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, z));
        // contention after a fresh reset: gnt0, gnt1, gnt0 with one IDLE cycle between
        vq.push_back(mk(1, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, z));
        for (int i = 0; i < 12; i++) begin
            logic [13:0] e;
            case (i % 8)
                0, 1:    e = g0r;
                2:       e = k0;
                3:       e = z;
                4, 5:    e = g1c;
                6:       e = k1;
                default: e = z;
            endcase
            vq.push_back(mk(0, 1, 3'b001, 4'h3, 1, 1, 3'b010, 4'h5, 0, e));
        end
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, z));
        // mid-access reset on a requester 1 access, then pointer must favour requester 0
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 1, 3'b010, 4'h6, 1, ob(0, 1, 0, 0, 3'b010, 4'h6, 1, 0, 1)));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 1, 3'b010, 4'h6, 1, ob(0, 1, 0, 0, 3'b010, 4'h6, 1, 0, 1)));
        vq.push_back(mk(1, 0, 3'b000, 4'h0, 0, 1, 3'b010, 4'h6, 1, z));
        vq.push_back(mk(0, 1, 3'b001, 4'h9, 0, 1, 3'b010, 4'h6, 1, ob(1, 0, 0, 0, 3'b001, 4'h9, 0, 1, 0)));
        vq.push_back(mk(0, 1, 3'b001, 4'h9, 0, 1, 3'b010, 4'h6, 1, ob(1, 0, 0, 0, 3'b001, 4'h9, 0, 1, 0)));
        vq.push_back(mk(0, 1, 3'b001, 4'h9, 0, 1, 3'b010, 4'h6, 1, k0));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, z));
        // unmapped address: granted and acked, no enable
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 1, 3'b111, 4'hC, 1, g1u));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 1, 3'b111, 4'hC, 1, g1u));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 1, 3'b111, 4'hC, 1, k1));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, z));
        // withdrawal during BUSY with changed inputs: access completes, no regrant
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 1, 3'b010, 4'h7, 1, g1w));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, g1w));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, k1));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, z));
        vq.push_back(mk(0, 0, 3'b000, 4'h0, 0, 0, 3'b000, 4'h0, 0, z));

        drive(vq[0]);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            @(posedge clk);
            #1;
            got = obs();
            n_tests++;
            if (got !== vq[i].exp) begin
                n_fail++;
                $display("FAIL vec%0d got=%h exp=%h", i, got, vq[i].exp);
            end
        end

        // continuous contention: strict alternation, one grant every HOLD+2 cycles
        @(negedge clk);
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        bus.req0   = 1'b1; bus.addr0 = 3'b001; bus.wdata0 = 4'h3; bus.we0 = 1'b1;
        bus.req1   = 1'b1; bus.addr1 = 3'b010; bus.wdata1 = 4'h5; bus.we1 = 1'b0;
        prev_any  = 1'b0;
        exp_owner = 1'b0;
        grants    = 0;
        acks      = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if ((bus.gnt0 && bus.gnt1) || (bus.ack0 && bus.ack1) || (bus.enable0 && bus.enable1)) begin
                n_fail++;
                $display("FAIL exclusive cycle%0d got gnt=%b%b ack=%b%b en=%b%b exp no pair high",
                         k, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.enable0, bus.enable1);
            end
            cur_any = bus.gnt0 | bus.gnt1;
            if (cur_any && !prev_any) begin
                n_tests++;
                if (bus.gnt1 !== exp_owner || k != 1 + (HOLD + 2) * grants
                    || bus.enable1 !== exp_owner || bus.enable0 !== !exp_owner) begin
                    n_fail++;
                    $display("FAIL rr_order cycle%0d got gnt1=%b en=%b%b exp gnt1=%b at cycle%0d",
                             k, bus.gnt1, bus.enable0, bus.enable1, exp_owner,
                             1 + (HOLD + 2) * grants);
                end
                exp_owner = ~exp_owner;
                grants++;
            end
            if (bus.ack0 || bus.ack1) acks++;
            prev_any = cur_any;
        end
        n_tests++;
        if (grants != 10) begin
            n_fail++;
            $display("FAIL grant_count got=%0d exp=10", grants);
        end
        n_tests++;
        if (acks != 10) begin
            n_fail++;
            $display("FAIL ack_count got=%0d exp=10", acks);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
